mips32_fetch_stage: RTL and testbench
=====================================

# mips32_fetch_stage

Instruction-fetch front end for the `pipe_MIPS32` pipeline. It owns the program counter and issues word reads to a synchronous instruction memory. Fetched instructions are buffered in a 2-entry queue and handed to the IF/ID boundary over a valid/ready handshake. It also handles branch redirects from EX/MEM and stops fetching after the HLT opcode.

## Interface
- `RESET_PC`, default 32'h0: PC loaded on reset; word address.
- `HLT_OP`, default 6'h3f: opcode (`ir[31:26]`) that halts fetch.
- `clk1`  in  1  pipeline clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `imem_rd`  out  1  read strobe to instruction memory.
- `imem_addr`  out  32  word address of the read; equals the PC.
- `imem_rdata`  in  32  read data, valid exactly one cycle after `imem_rd`.
- `redirect`  in  1  taken branch from EX/MEM; one-cycle pulse.
- `redirect_pc`  in  32  branch target word address.
- `id_ready`  in  1  decode stage accepts an instruction this cycle.
- `if_valid`  out  1  `if_ir`/`if_npc` hold a valid instruction.
- `if_ir`  out  32  instruction word.
- `if_npc`  out  32  address of the instruction + 1.
- `halted`  out  1  HLT has been fetched; no further reads are issued.

## Operation
- The PC is word-addressed and increments by 1 on each issued read. It wraps from 32'hffffffff to 0 with no flag.
- **Read issue:** `imem_rd` = RUN && !redirect && (queue occupancy + in-flight reads) < 2. Each issued read posts PC and PC+1 to an in-flight register, and the PC advances.
- **Response:** one cycle after issue, {`imem_rdata`, npc} is pushed into the queue unless the in-flight entry has been killed.
- **Output:** `if_valid` = queue non-empty && !redirect. A transfer occurs when `if_valid` && `id_ready`, and it pops the head entry.
- **Redirect:**
  - Clears the queue.
  - Kills the in-flight read.
  - Sets PC = `redirect_pc`.
  - Clears `halted`, because the HLT may have been on the wrong path.
  - Returns the state machine to RUN.
  - Redirect has priority over push, pop and issue in the same cycle.
- **States:**
  - RESET: entered while `reset` is high.
  - IDLE: exactly one cycle after reset is released; no read is issued.
  - RUN: issues reads.
  - HALT: entered when a pushed word has `ir[31:26]` = `HLT_OP`. In HALT no reads are issued; already-queued entries, including the HLT itself, still drain to decode.
  - Exit from HALT is by redirect only.
- A push and a pop in the same cycle leave the occupancy unchanged. A push into a full queue cannot occur, because the issue credit rule prevents it.
- A read issued in the same cycle that HLT is pushed still returns, but its response is dropped.

## Timing
- **Reset values:** `imem_rd`=0, `imem_addr`=`RESET_PC`, `if_valid`=0, `if_ir`=0, `if_npc`=0, `halted`=0; queue empty; nothing in flight.
- **Latency:** read issued in cycle t; pushed at the end of t+1; `if_valid` high in t+2.
- **Throughput:** 1 instruction/cycle while `id_ready` is held high.
- **Backpressure:** with `id_ready` low, at most 2 instructions are held, and issue stops when the credit is exhausted. When `id_ready` returns high, there is no bubble before the queued instructions flow.
- **Redirect in cycle t:** `if_valid`=0 in t; read of `redirect_pc` in t+1; its instruction is valid in t+3.
- **`halted`:** rises in the cycle after the HLT push.
- **Reset mid-operation:** takes effect asynchronously; all in-flight data is discarded.

## Structure
- Shared package `mips32_pkg`:
  - opcode constants (HLT=6'h3f, ADD, ADDI, …);
  - the IF/ID record type {ir, npc};
  - the state enum {IDLE, RUN, HALT}.
- One sub-module, `fetch_queue`: a 2-entry FIFO with synchronous flush, push/pop, full/empty, and occupancy count.
- The PC, in-flight tracking and state machine live in the top level.

## Test plan
- **Straight line:** load imem[0..3] = 2801000a, 28020014, 28030019, 0ce77800; hold `id_ready`=1.
  - Expect `if_valid` from cycle 2.
  - `if_ir` takes those four values on consecutive cycles with `if_npc` = 1, 2, 3, 4.
- **Backpressure:** run as above but hold `id_ready`=0 for cycles 2–6.
  - `imem_rd` stays low after 2 outstanding reads.
  - After release, 2801000a then 28020014 are delivered without a gap or duplicate.
- **Redirect:** pulse `redirect` with `redirect_pc`=8 in cycle 4.
  - `if_valid`=0 in cycle 4.
  - The queue is flushed.
  - `imem_addr`=8 in cycle 5.
  - The next delivered instruction is imem[8] with `if_npc`=9.
- **Halt:** imem[8]=fc000000, start PC=8.
  - fc000000 is delivered.
  - `halted`=1.
  - `imem_rd` stays 0 for 10 cycles.
  - A redirect to 0 clears `halted` and fetching resumes.
- **Reset mid-stream:** assert `reset` with a full queue and a read in flight.
  - All outputs return to their reset values immediately.
  - The first instruction after release is imem[`RESET_PC`].
- **Wrap:** redirect to 32'hffffffff; the next `imem_addr` after that is 0.

Source files
------------

// File: rtl/mips32_pkg.sv
// Shared types and constants for the pipe_MIPS32 front end.
// Holds opcode encodings, the IF/ID record and the fetch state enum.
// No logic lives here.
package mips32_pkg;

  // Opcode field values (ir[31:26])
  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_SUB   = 6'h01;
  localparam logic [5:0] OP_AND   = 6'h02;
  localparam logic [5:0] OP_OR    = 6'h03;
  localparam logic [5:0] OP_SLT   = 6'h04;
  localparam logic [5:0] OP_MUL   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h08;
  localparam logic [5:0] OP_SW    = 6'h09;
  localparam logic [5:0] OP_ADDI  = 6'h0a;
  localparam logic [5:0] OP_SUBI  = 6'h0b;
  localparam logic [5:0] OP_SLTI  = 6'h0c;
  localparam logic [5:0] OP_BNEQZ = 6'h0d;
  localparam logic [5:0] OP_BEQZ  = 6'h0e;
  localparam logic [5:0] OP_HLT   = 6'h3f;

  // Record handed across the IF/ID boundary
  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } if_id_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALT
  } fetch_state_t;

  function automatic logic [5:0] opcode_of(input logic [31:0] ir);
    return ir[31:26];
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO with synchronous flush, occupancy count and full/empty flags.
// Latency: a pushed entry is visible at the head on the next cycle.
// Backpressure: none internally; the producer must not push when full without popping.
module fetch_queue #(
  parameter int W = 64
) (
  input  logic         clk1,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem0, mem1;
  logic         wr_ptr, rd_ptr;
  logic [1:0]   cnt;

  // Storage, pointers and count; flush wins over push/pop
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      mem0   <= '0;
      mem1   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr) mem1 <= push_dat;
        else        mem0 <= push_dat;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Head entry and status flags
  always_comb begin
    head_dat = rd_ptr ? mem1 : mem0;
    full     = (cnt == 2'd2);
    empty    = (cnt == 2'd0);
    count    = cnt;
  end

endmodule

// File: rtl/mips32_fetch_stage.sv
// Instruction fetch: PC, one-deep in-flight read tracking, 2-entry IF/ID queue, halt/redirect FSM.
// Latency: read issued in t, instruction valid to decode in t+2; redirect target valid in t+3.
// Backpressure: id_ready low holds up to 2 instructions; reads stop once queue+in-flight credit is used.
module mips32_fetch_stage
  import mips32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [5:0]  HLT_OP   = OP_HLT
) (
  input  logic        clk1,
  input  logic        reset,
  output logic        imem_rd,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_ir,
  output logic [31:0] if_npc,
  output logic        halted
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc;
  logic         infl_vld;
  logic [31:0]  infl_npc;
  logic         push, pop, issue;
  logic         q_full, q_empty;
  logic [1:0]   q_count;
  logic [2:0]   used;
  if_id_t       push_dat, head_dat;

  // Handshake, credit and response steering
  always_comb begin
    pop      = !q_empty && !redirect && id_ready;
    // A response arriving after HLT was pushed (state already HALT) is dropped.
    push     = infl_vld && !redirect && (state == ST_RUN) && (!q_full || pop);
    // Counting this cycle's pop lets a steady stream issue one read per cycle.
    used     = {1'b0, q_count} + {2'b00, infl_vld} - {2'b00, pop};
    issue    = (state == ST_RUN) && !redirect && (used < 3'd2);
    push_dat = '{ir: imem_rdata, npc: infl_npc};
  end

  // Next-state logic: IDLE for one cycle, RUN until HLT is queued, redirect returns to RUN
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: state_nxt = ST_RUN;
      ST_RUN:  if (push && (opcode_of(imem_rdata) == HLT_OP)) state_nxt = ST_HALT;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IDLE;
    endcase
    if (redirect) state_nxt = ST_RUN;
  end

  // State register
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // PC and in-flight read; redirect kills the outstanding read and reloads the PC
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      infl_vld <= 1'b0;
      infl_npc <= '0;
    end else if (redirect) begin
      pc       <= redirect_pc;
      infl_vld <= 1'b0;
    end else begin
      infl_vld <= issue;
      if (issue) begin
        pc       <= pc + 32'd1;
        infl_npc <= pc + 32'd1;
      end
    end
  end

  fetch_queue #(.W($bits(if_id_t))) u_queue (
    .clk1     (clk1),
    .reset    (reset),
    .flush    (redirect),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .full     (q_full),
    .empty    (q_empty),
    .count    (q_count)
  );

  // Output drive
  always_comb begin
    imem_rd   = issue;
    imem_addr = pc;
    if_valid  = !q_empty && !redirect;
    if_ir     = head_dat.ir;
    if_npc    = head_dat.npc;
    halted    = (state == ST_HALT);
  end

endmodule

// File: tb/tb_mips32_fetch_stage.sv
module tb_mips32_fetch_stage;

  logic        clk1 = 1'b0;
  logic        reset;
  logic        imem_rd;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_ir;
  logic [31:0] if_npc;
  logic        halted;

  logic [31:0] imem [64];

  int n_vec  = 0;
  int n_miss = 0;

  localparam logic [31:0] I0 = 32'h2801000a;
  localparam logic [31:0] I1 = 32'h28020014;
  localparam logic [31:0] I2 = 32'h28030019;
  localparam logic [31:0] I3 = 32'h0ce77800;
  localparam logic [31:0] R8 = 32'h01082020;
  localparam logic [31:0] HL = 32'hfc000000;

  typedef struct {
    bit          rst;
    bit          redir;
    logic [31:0] rpc;
    bit          rdy;
    bit          e_rd;
    logic [31:0] e_addr;
    bit          e_vld;
    logic [31:0] e_ir;
    logic [31:0] e_npc;
    bit          e_hlt;
  } vec_t;

  vec_t vq[$];

  mips32_fetch_stage dut (
    .clk1        (clk1),
    .reset       (reset),
    .imem_rd     (imem_rd),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_ready    (id_ready),
    .if_valid    (if_valid),
    .if_ir       (if_ir),
    .if_npc      (if_npc),
    .halted      (halted)
  );

  always #5 clk1 = ~clk1;

  // Synchronous instruction memory: data one cycle after the strobe
  always @(posedge clk1) begin
    if (imem_rd) imem_rdata <= imem[imem_addr[5:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input bit rst, input bit redir, input logic [31:0] rpc, input bit rdy,
                     input bit e_rd, input logic [31:0] e_addr, input bit e_vld,
                     input logic [31:0] e_ir, input logic [31:0] e_npc, input bit e_hlt);
    vec_t v;
    v.rst = rst; v.redir = redir; v.rpc = rpc; v.rdy = rdy;
    v.e_rd = e_rd; v.e_addr = e_addr; v.e_vld = e_vld;
    v.e_ir = e_ir; v.e_npc = e_npc; v.e_hlt = e_hlt;
    vq.push_back(v);
  endtask

  // Reset released just after a rising edge so the following full cycle is IDLE
  task automatic do_reset();
    reset    = 1'b1;
    redirect = 1'b0;
    id_ready = 1'b0;
    repeat (2) @(posedge clk1);
    #1 reset = 1'b0;
  endtask

  // Drive inputs at the falling edge, sample 1 time unit later
  task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy);
    @(negedge clk1);
    redirect    = redir;
    redirect_pc = rpc;
    id_ready    = rdy;
    #1;
    n_vec++;
  endtask

  task automatic chk_out(input string tag, input bit e_rd, input logic [31:0] e_addr,
                         input bit e_vld, input logic [31:0] e_ir, input logic [31:0] e_npc,
                         input bit e_hlt);
    chk({tag, ".imem_rd"},   {31'd0, imem_rd},  {31'd0, e_rd});
    chk({tag, ".imem_addr"}, imem_addr,         e_addr);
    chk({tag, ".if_valid"},  {31'd0, if_valid}, {31'd0, e_vld});
    chk({tag, ".halted"},    {31'd0, halted},   {31'd0, e_hlt});
    if (e_vld) begin
      chk({tag, ".if_ir"},  if_ir,  e_ir);
      chk({tag, ".if_npc"}, if_npc, e_npc);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = 32'h20000000 | i;
    imem[0] = I0; imem[1] = I1; imem[2] = I2; imem[3] = I3; imem[8] = R8;
    redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0; reset = 1'b1;

    // Straight line, id_ready held high
    add(1,0,0,1, 0,0,0,0,0,0);
    add(0,0,0,1, 1,0,0,0,0,0);
    add(0,0,0,1, 1,1,0,0,0,0);
    add(0,0,0,1, 1,2,1,I0,1,0);
    add(0,0,0,1, 1,3,1,I1,2,0);
    add(0,0,0,1, 1,4,1,I2,3,0);
    add(0,0,0,1, 1,5,1,I3,4,0);
    // Backpressure: id_ready low in cycles 2..6
    add(1,0,0,1, 0,0,0,0,0,0);
    add(0,0,0,1, 1,0,0,0,0,0);
    add(0,0,0,1, 1,1,0,0,0,0);
    for (int c = 2; c <= 6; c++) add(0,0,0,0, 0,2,1,I0,1,0);
    add(0,0,0,1, 1,2,1,I0,1,0);
    add(0,0,0,1, 1,3,1,I1,2,0);
    add(0,0,0,1, 1,4,1,I2,3,0);
    add(0,0,0,1, 1,5,1,I3,4,0);
    // Redirect to 8 in cycle 4
    add(1,0,0,1, 0,0,0,0,0,0);
    add(0,0,0,1, 1,0,0,0,0,0);
    add(0,0,0,1, 1,1,0,0,0,0);
    add(0,0,0,1, 1,2,1,I0,1,0);
    add(0,0,0,1, 1,3,1,I1,2,0);
    add(0,1,8,1, 0,4,0,0,0,0);
    add(0,0,0,1, 1,8,0,0,0,0);
    add(0,0,0,1, 1,9,0,0,0,0);
    add(0,0,0,1, 1,10,1,R8,9,0);
    add(0,0,0,1, 1,11,1,32'h20000009,10,0);

    // Reset state before any release
    @(posedge clk1);
    #1;
    n_vec++;
    chk_out("rst", 0, 32'h0, 0, 0, 0, 0);
    chk("rst.if_ir",  if_ir,  32'h0);
    chk("rst.if_npc", if_npc, 32'h0);

    foreach (vq[i]) begin
      if (vq[i].rst) do_reset();
      step(vq[i].redir, vq[i].rpc, vq[i].rdy);
      chk_out($sformatf("vec%0d", i), vq[i].e_rd, vq[i].e_addr, vq[i].e_vld,
              vq[i].e_ir, vq[i].e_npc, vq[i].e_hlt);
    end

    // Halt: start at 8 where HLT sits; the read of 9 issued alongside the push is dropped
    imem[8] = HL;
    do_reset();
    step(0,0,1);       chk_out("hlt.idle", 0, 0, 0, 0, 0, 0);
    step(1,8,1);       chk_out("hlt.c0",   0, 0, 0, 0, 0, 0);
    step(0,0,1);       chk_out("hlt.c1",   1, 8, 0, 0, 0, 0);
    step(0,0,1);       chk_out("hlt.c2",   1, 9, 0, 0, 0, 0);
    step(0,0,1);       chk_out("hlt.c3",   0, 10, 1, HL, 9, 1);
    for (int k = 0; k < 10; k++) begin
      step(0,0,1);     chk_out($sformatf("hlt.idle%0d", k), 0, 10, 0, 0, 0, 1);
    end
    step(1,0,1);       chk_out("hlt.redir", 0, 10, 0, 0, 0, 1);
    step(0,0,1);       chk_out("hlt.r1",   1, 0, 0, 0, 0, 0);
    step(0,0,1);       chk_out("hlt.r2",   1, 1, 0, 0, 0, 0);
    step(0,0,1);       chk_out("hlt.r3",   1, 2, 1, I0, 1, 0);

    // Reset mid-stream: queue full and a read being issued
    do_reset();
    step(0,0,0);       chk_out("mrst.idle", 0, 0, 0, 0, 0, 0);
    step(0,0,0);       chk_out("mrst.c0",   1, 0, 0, 0, 0, 0);
    step(0,0,0);       chk_out("mrst.c1",   1, 1, 0, 0, 0, 0);
    step(0,0,0);       chk_out("mrst.c2",   0, 2, 1, I0, 1, 0);
    step(0,0,0);       chk_out("mrst.c3",   0, 2, 1, I0, 1, 0);
    step(0,0,1);       chk_out("mrst.c4",   1, 2, 1, I0, 1, 0);
    #1 reset = 1'b1;
    #1;
    n_vec++;
    chk_out("mrst.async", 0, 0, 0, 0, 0, 0);
    chk("mrst.if_ir",  if_ir,  32'h0);
    chk("mrst.if_npc", if_npc, 32'h0);
    @(posedge clk1);
    #1 reset = 1'b0;
    step(0,0,1);       chk_out("mrst.idle2", 0, 0, 0, 0, 0, 0);
    step(0,0,1);       chk_out("mrst.r0",    1, 0, 0, 0, 0, 0);
    step(0,0,1);       chk_out("mrst.r1",    1, 1, 0, 0, 0, 0);
    step(0,0,1);       chk_out("mrst.r2",    1, 2, 1, I0, 1, 0);

    // PC wrap at the top of the address space
    do_reset();
    step(0,0,1);              chk_out("wrap.idle", 0, 0, 0, 0, 0, 0);
    step(1,32'hffffffff,1);   chk_out("wrap.c0",   0, 0, 0, 0, 0, 0);
    step(0,0,1);              chk_out("wrap.c1",   1, 32'hffffffff, 0, 0, 0, 0);
    step(0,0,1);              chk_out("wrap.c2",   1, 0, 0, 0, 0, 0);
    step(0,0,1);              chk_out("wrap.c3",   1, 1, 1, 32'h2000003f, 0, 0);
    step(0,0,1);              chk_out("wrap.c4",   1, 2, 1, I0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
